multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32I-subset core; replaces per-instruction combinational decode with an FSM.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB with ready-handshakes to instruction and data memory.
- Drives the same datapath control signals (aluop, alusrc, memread, memwrite, memtoreg, regwrite, jal_select) plus PC/IR write enables.
- Adds a wait-state timeout that traps on a hung memory.

Parameters:
- TIMEOUT_CYCLES, 16, maximum wait cycles in FETCH or MEM before trapping. Legal range 1..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- opcode  input  7  instr[6:0] from the IR; sampled in DECODE only.
- branch_taken  input  1  branch compare result from the ALU; sampled in EXEC.
- imem_ready  input  1  instruction memory data valid.
- dmem_ready  input  1  data memory access complete.
- imem_req  output  1  instruction fetch request.
- ir_write  output  1  IR load enable.
- pc_write  output  1  PC update enable.
- pc_src  output  2  PC source: 00 = PC+4, 01 = PC+imm, 10 = rs1+imm (jalr).
- aluop  output  2  ALU operation class.
- alusrc  output  1  ALU B operand: 0 = rs2, 1 = imm.
- memread  output  1  data memory read (also the dmem request for loads).
- memwrite  output  1  data memory write (also the dmem request for stores).
- memtoreg  output  1  writeback from memory.
- regwrite  output  1  register file write enable.
- jal_select  output  1  writeback PC+4 (link).
- retire  output  1  one-cycle pulse per completed instruction.
- trap  output  1  sticky fault flag.
- bus_error  output  1  sticky flag: the trap was caused by a timeout.
- state  output  3  current state (debug).

Behaviour:
- States and encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
- Reset (async, rst_n = 0):
  - state = FETCH, op_q = 0, wait counter = 0, trap = 0, bus_error = 0.
  - All outputs are 0 while reset is asserted.
  - A reset mid-instruction aborts it with no pc_write or regwrite.
- Output gating:
  - All outputs are decoded from state, op_q and the ready inputs.
  - Unlisted outputs are 0.
  - aluop/alusrc are driven from op_q in EXEC, MEM and WB; they are 0 in FETCH, DECODE and TRAP.
- aluop/alusrc by opcode:
  - R (0110011): 10/0.
  - I (0010011): 00/1.
  - I_LD (0000011): 11/1.
  - S (0100011): 11/1.
  - SB (1100011): 01/0.
  - J (1101111): 01/1.
  - J_R (1100111): 01/1.
- FETCH:
  - imem_req = 1.
  - On imem_ready: ir_write = 1 and go to DECODE.
- DECODE:
  - op_q <= opcode.
  - Legal opcode: go to EXEC.
  - Otherwise: trap <= 1 and go to TRAP.
- EXEC:
  - R, I, J, J_R: go to WB.
  - I_LD, S: go to MEM.
  - SB: pc_write = 1, pc_src = branch_taken ? 01 : 00, retire = 1, go to FETCH.
- MEM:
  - memread = 1 for I_LD; memwrite = 1 for S.
  - Both are held until dmem_ready.
  - On dmem_ready, I_LD goes to WB.
  - On dmem_ready, S does pc_write = 1, pc_src = 00, retire = 1, and goes to FETCH.
- WB:
  - regwrite = 1, pc_write = 1, retire = 1, then go to FETCH.
  - memtoreg = 1 for I_LD.
  - jal_select = 1 for J and J_R.
  - pc_src is 01 for J, 10 for J_R, 00 otherwise.
- Latency with zero wait states:
  - SB: 3 cycles.
  - R, I, S, J, J_R: 4 cycles.
  - I_LD: 5 cycles.
- Timeout:
  - The 8-bit wait counter clears on entry to FETCH or MEM.
  - It increments each cycle ready is low.
  - When it reaches TIMEOUT_CYCLES with ready still low: trap <= 1, bus_error <= 1, go to TRAP.
  - Ready arriving in the same cycle the limit is reached wins; there is no trap.
- TRAP:
  - Absorbing state; all request and write outputs are 0.
  - trap and bus_error hold until rst_n.
- Ready inputs are ignored outside their own wait state; a stray imem_ready in MEM has no effect.
- retire never coincides with trap.

Decomposition:
- Shared package core_ctrl_pkg:
  - Opcode localparams (R, I, I_LD, S, SB, J, J_R).
  - State encodings.
  - pc_src encodings.
  - aluop encodings.
- Sub-module op_decode: purely combinational. Maps op_q to {aluop, alusrc, is_load, is_store, is_branch, is_jump, is_jalr, legal}; the FSM consumes these.

Test Plan:
- add (0110011), imem_ready high on the first FETCH cycle -> state 0,1,2,4,0; regwrite = 1 and retire = 1 only in the WB cycle; aluop = 10 in EXEC and WB; pc_src = 00.
- lw (0000011), imem_ready after 2 wait cycles, dmem_ready after 3 -> memread high for 4 MEM cycles; WB shows memtoreg = 1, regwrite = 1; total 10 cycles to retire.
- beq (1100011) with branch_taken = 1, then again with 0 -> EXEC shows pc_write = 1 with pc_src 01, then 00; regwrite stays 0; retire after 3 cycles.
- jalr (1100111) -> WB shows regwrite = 1, jal_select = 1, pc_src = 10; jal (1101111) -> pc_src = 01.
- Illegal opcode 0000000 -> DECODE to TRAP; trap = 1, bus_error = 0; imem_req stays 0 for 20 cycles; rst_n low clears trap.
- sw with dmem_ready never asserted, TIMEOUT_CYCLES = 16 -> TRAP after 16 MEM cycles with bus_error = 1; a repeat with dmem_ready on the 16th cycle retires with no trap.
- rst_n pulsed low during MEM of sw -> memwrite drops immediately; state = FETCH after release; no retire.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle control path: opcodes, FSM states, pc_src, aluop.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: opcode localparams, state_e, PC/ALU encodings, dec_t decoder bundle.
package core_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_I_LD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_J_R  = 7'b1100111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;  // I-type arithmetic
  localparam logic [1:0] ALU_BR  = 2'b01;  // branch compare / jump target
  localparam logic [1:0] ALU_R   = 2'b10;  // R-type, funct-decoded
  localparam logic [1:0] ALU_MEM = 2'b11;  // load/store address

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_jalr;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/data memory handshake bundle between the sequencer and the memories.
// Latency: none (wires only).
// Backpressure: memories stall the sequencer by holding imem_ready/dmem_ready low.
// Signals: imem_req/imem_ready (fetch), memread/memwrite/dmem_ready (data access).
interface multicycle_control_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_ready;
  logic memread;
  logic memwrite;

  modport master (output imem_req, memread, memwrite, input imem_ready, dmem_ready);
  modport slave  (input imem_req, memread, memwrite, output imem_ready, dmem_ready);
endinterface

// File: rtl/multicycle_control_op_decode.sv
// Opcode classifier feeding the sequencer: ALU class, operand select and instruction kind.
// Latency: purely combinational.
// Backpressure: n/a.
// Ports: op (7-bit opcode) in, dec (dec_t bundle) out.
module op_decode
  import core_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    dec.legal = 1'b1;
    case (op)
      OP_R:    begin dec.aluop = ALU_R;   dec.alusrc = 1'b0; end
      OP_I:    begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; end
      OP_I_LD: begin dec.aluop = ALU_MEM; dec.alusrc = 1'b1; dec.is_load  = 1'b1; end
      OP_S:    begin dec.aluop = ALU_MEM; dec.alusrc = 1'b1; dec.is_store = 1'b1; end
      OP_SB:   begin dec.aluop = ALU_BR;  dec.alusrc = 1'b0; dec.is_branch = 1'b1; end
      OP_J:    begin dec.aluop = ALU_BR;  dec.alusrc = 1'b1; dec.is_jump = 1'b1; end
      OP_J_R:  begin dec.aluop = ALU_BR;  dec.alusrc = 1'b1; dec.is_jalr = 1'b1; end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath controls, with memory wait timeout.
// Latency: SB 3 cycles, R/I/S/J/J_R 4 cycles, load 5 cycles, plus memory wait states.
// Backpressure: stalls in FETCH/MEM while ready is low; traps after TIMEOUT_CYCLES wait cycles.
// Ports: clk, rst_n, opcode, branch_taken, bus (memory handshake), datapath controls, retire/trap/bus_error/state.
module multicycle_control
  import core_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  multicycle_control_if.master bus,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [1:0]           aluop,
  output logic                 alusrc,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 jal_select,
  output logic                 retire,
  output logic                 trap,
  output logic                 bus_error,
  output logic [2:0]           state
);

  // The counter holds the number of wait cycles already spent, so the limit
  // is hit on the TIMEOUT_CYCLES-th waiting cycle if ready is still low.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q;
  logic [6:0] op_q;
  logic [7:0] wcnt;
  logic       trap_q;
  logic       buserr_q;
  logic [6:0] dec_op;
  dec_t       dec;

  // In DECODE the incoming opcode is classified for the legality check;
  // everywhere else the latched opcode drives the controls.
  assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;

  op_decode u_op_decode (
    .op  (dec_op),
    .dec (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      op_q     <= '0;
      wcnt     <= '0;
      trap_q   <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.imem_ready) begin
            state_q <= ST_DECODE;
          end else if (wcnt == WAIT_LIMIT) begin
            trap_q   <= 1'b1;
            buserr_q <= 1'b1;
            state_q  <= ST_TRAP;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        ST_DECODE: begin
          op_q <= opcode;
          if (dec.legal) begin
            state_q <= ST_EXEC;
          end else begin
            trap_q  <= 1'b1;
            state_q <= ST_TRAP;
          end
        end
        ST_EXEC: begin
          wcnt <= '0;
          if (dec.is_branch)                  state_q <= ST_FETCH;
          else if (dec.is_load || dec.is_store) state_q <= ST_MEM;
          else                                state_q <= ST_WB;
        end
        ST_MEM: begin
          if (bus.dmem_ready) begin
            wcnt    <= '0;
            state_q <= dec.is_load ? ST_WB : ST_FETCH;
          end else if (wcnt == WAIT_LIMIT) begin
            trap_q   <= 1'b1;
            buserr_q <= 1'b1;
            state_q  <= ST_TRAP;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        ST_WB: begin
          wcnt    <= '0;
          state_q <= ST_FETCH;
        end
        ST_TRAP: state_q <= ST_TRAP;
        default: begin
          trap_q  <= 1'b1;
          state_q <= ST_TRAP;
        end
      endcase
    end
  end

  // Controls are decoded from state so a ready can be consumed the cycle it
  // arrives; gating with rst_n keeps every output low while reset is held.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    aluop        = 2'b00;
    alusrc       = 1'b0;
    memtoreg     = 1'b0;
    regwrite     = 1'b0;
    jal_select   = 1'b0;
    retire       = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          bus.imem_req = 1'b1;
          ir_write     = bus.imem_ready;
        end
        ST_EXEC: begin
          aluop  = dec.aluop;
          alusrc = dec.alusrc;
          if (dec.is_branch) begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
            retire   = 1'b1;
          end
        end
        ST_MEM: begin
          aluop        = dec.aluop;
          alusrc       = dec.alusrc;
          bus.memread  = dec.is_load;
          bus.memwrite = dec.is_store;
          if (dec.is_store && bus.dmem_ready) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
        ST_WB: begin
          aluop      = dec.aluop;
          alusrc     = dec.alusrc;
          regwrite   = 1'b1;
          pc_write   = 1'b1;
          retire     = 1'b1;
          memtoreg   = dec.is_load;
          jal_select = dec.is_jump || dec.is_jalr;
          pc_src     = dec.is_jump ? PC_IMM : (dec.is_jalr ? PC_JALR : PC_PLUS4);
        end
        default: ;
      endcase
    end
  end

  assign trap      = trap_q;
  assign bus_error = buserr_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a memory responder and a retire scoreboard.
// Latency: n/a (testbench).
// Backpressure: memory model inserts a programmable number of wait cycles per request.
module tb_multicycle_control;
  import core_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       ir_write, pc_write, alusrc, memtoreg, regwrite, jal_select, retire, trap, bus_error;
  logic [1:0] pc_src, aluop;
  logic [2:0] state;

  multicycle_control_if bus ();

  multicycle_control #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken), .bus(bus),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .aluop(aluop), .alusrc(alusrc),
    .memtoreg(memtoreg), .regwrite(regwrite), .jal_select(jal_select), .retire(retire),
    .trap(trap), .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         lat;
    logic       rw, mt, js, pw;
    logic [1:0] pcs;
  } exp_t;

  typedef struct packed {
    logic       retired;
    logic       rw, mt, js, pw, tr;
    logic [1:0] pcs;
    int         memcyc, rwcnt, reqcnt;
  } obs_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] st_tr [64];
  logic [1:0] alu_tr[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Release reset just after a rising edge so the next cycle is a clean first FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Acts as the memories for one instruction; returns after retire or maxcyc cycles.
  task automatic run_instr(input logic [6:0] op, input int iwait, input int dwait, input logic br,
                           input logic stray, input int maxcyc, output int lat, output obs_t o);
    int   icnt = 0;
    int   dcnt = 0;
    logic dec_nxt = 1'b0;
    lat = 0;
    o = '0;
    for (int i = 0; i < maxcyc; i++) begin
      @(negedge clk);
      // The opcode is only meaningful in DECODE; garbage elsewhere checks it is latched.
      opcode = dec_nxt ? op : 7'h7F;
      dec_nxt = 1'b0;
      branch_taken = br;
      if (bus.imem_req) begin
        bus.imem_ready = (icnt >= iwait);
        icnt++;
        o.reqcnt++;
      end else begin
        bus.imem_ready = stray;
      end
      if (bus.memread || bus.memwrite) begin
        bus.dmem_ready = (dcnt >= dwait);
        dcnt++;
        o.memcyc++;
      end else begin
        bus.dmem_ready = stray;
      end
      #1;
      if (bus.imem_req && bus.imem_ready) dec_nxt = 1'b1;
      st_tr[i]  = state;
      alu_tr[i] = aluop;
      if (regwrite) o.rwcnt++;
      if (retire) begin
        o.retired = 1'b1;
        o.rw = regwrite; o.mt = memtoreg; o.js = jal_select;
        o.pw = pc_write; o.tr = trap; o.pcs = pc_src;
        lat = i + 1;
        break;
      end
    end
  endtask

  // Push the expectation, run the instruction, pop and compare at retire.
  task automatic sb_run(input string nm, input logic [6:0] op, input int iwait, input int dwait,
                        input logic br, input logic stray, input exp_t e, output obs_t o);
    int   lat;
    exp_t x;
    exp_q.push_back(e);
    run_instr(op, iwait, dwait, br, stray, 40, lat, o);
    chk({nm, "_retired"}, 32'(o.retired), 32'd1);
    if (o.retired && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk({nm, "_latency"}, lat, x.lat);
      chk({nm, "_regwrite"}, 32'(o.rw), 32'(x.rw));
      chk({nm, "_memtoreg"}, 32'(o.mt), 32'(x.mt));
      chk({nm, "_jal_select"}, 32'(o.js), 32'(x.js));
      chk({nm, "_pc_write"}, 32'(o.pw), 32'(x.pw));
      chk({nm, "_pc_src"}, 32'(o.pcs), 32'(x.pcs));
      chk({nm, "_trap"}, 32'(o.tr), 32'd0);
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   lat;
    int   nreq;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;

    // Reset state: everything low, FETCH not yet requesting.
    @(negedge clk);
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_trap_buserr", {trap, bus_error, pc_write, regwrite, retire}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // add: no wait states, check state trace and ALU class per phase.
    sb_run("add", OP_R, 0, 0, 1'b0, 1'b0, '{lat:4, rw:1, mt:0, js:0, pw:1, pcs:2'b00}, o);
    chk("add_states", {st_tr[0], st_tr[1], st_tr[2], st_tr[3]}, {3'd0, 3'd1, 3'd2, 3'd4});
    chk("add_aluop", {alu_tr[0], alu_tr[1], alu_tr[2], alu_tr[3]}, {2'b00, 2'b00, 2'b10, 2'b10});
    chk("add_regwrite_cnt", o.rwcnt, 1);

    // lw: 2 fetch waits, 3 data waits, stray readies outside their wait states.
    sb_run("lw", OP_I_LD, 2, 3, 1'b0, 1'b1, '{lat:10, rw:1, mt:1, js:0, pw:1, pcs:2'b00}, o);
    chk("lw_memread_cycles", o.memcyc, 4);
    chk("lw_exec_aluop", 32'(alu_tr[4]), 32'(2'b11));

    sb_run("beq_t", OP_SB, 0, 0, 1'b1, 1'b0, '{lat:3, rw:0, mt:0, js:0, pw:1, pcs:2'b01}, o);
    chk("beq_t_regwrite_cnt", o.rwcnt, 0);
    sb_run("beq_nt", OP_SB, 0, 0, 1'b0, 1'b0, '{lat:3, rw:0, mt:0, js:0, pw:1, pcs:2'b00}, o);
    sb_run("jalr", OP_J_R, 0, 0, 1'b0, 1'b0, '{lat:4, rw:1, mt:0, js:1, pw:1, pcs:2'b10}, o);
    sb_run("jal", OP_J, 1, 0, 1'b0, 1'b0, '{lat:5, rw:1, mt:0, js:1, pw:1, pcs:2'b01}, o);
    sb_run("addi", OP_I, 0, 0, 1'b0, 1'b0, '{lat:4, rw:1, mt:0, js:0, pw:1, pcs:2'b00}, o);
    chk("addi_exec_alusrc_aluop", {alu_tr[2]}, 32'(2'b00));
    sb_run("sw", OP_S, 0, 0, 1'b0, 1'b0, '{lat:4, rw:0, mt:0, js:0, pw:1, pcs:2'b00}, o);

    // Illegal opcode: DECODE traps, no bus error, no further fetches.
    run_instr(7'b0000000, 0, 0, 1'b0, 1'b0, 3, lat, o);
    chk("ill_retired", 32'(o.retired), 32'd0);
    chk("ill_state", 32'(state), 32'd7);
    chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_bus_error", 32'(bus_error), 32'd0);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.imem_ready = 1'b1;
      #1;
      if (bus.imem_req || retire) nreq++;
    end
    chk("ill_no_req_20", nreq, 0);
    do_reset();
    #1;
    chk("ill_rst_trap", 32'(trap), 32'd0);
    chk("ill_rst_state", 32'(state), 32'd0);

    // sw with a hung data memory: exactly 16 MEM cycles, then a bus-error trap.
    run_instr(OP_S, 0, 1000, 1'b0, 1'b0, 24, lat, o);
    chk("to_retired", 32'(o.retired), 32'd0);
    chk("to_mem_cycles", o.memcyc, 16);
    chk("to_state", 32'(state), 32'd7);
    chk("to_trap_buserr", {trap, bus_error}, 32'b11);
    do_reset();

    // Ready on the 16th MEM cycle wins over the timeout.
    sb_run("sw_lim", OP_S, 0, 15, 1'b0, 1'b0, '{lat:19, rw:0, mt:0, js:0, pw:1, pcs:2'b00}, o);
    chk("sw_lim_bus_error", 32'(bus_error), 32'd0);

    // Hung instruction memory traps from FETCH after 16 requests.
    run_instr(OP_R, 1000, 0, 1'b0, 1'b0, 20, lat, o);
    chk("fto_req_cycles", o.reqcnt, 16);
    chk("fto_trap_buserr", {state, trap, bus_error}, {3'd7, 2'b11});
    do_reset();

    // Reset mid-MEM of a store aborts it with no write or retire.
    run_instr(OP_S, 0, 1000, 1'b0, 1'b0, 5, lat, o);
    chk("rmem_memwrite_before", 32'(bus.memwrite), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmem_outputs_low", {bus.memwrite, pc_write, regwrite, retire, state}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    #1;
    chk("rmem_state_fetch", {state, bus.imem_req, retire}, {3'd0, 1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
